imem_dmem_arbiter: RTL and testbench

- Shares one single-port synchronous block RAM (1-cycle read latency) between two requesters: the core's instruction-fetch port (I) and its load/store port (D).
- Sits between the pipelined core and a unified code/data RAM, replacing the split imem/dmem arrangement.
- Grants one access per cycle and returns read data one cycle after grant.
- Drives `core_stall` so the core holds its fetch stage when I loses arbitration.

---
 rtl/imem_dmem_arbiter_pkg.sv | 20 ++
 rtl/imem_dmem_arbiter_if.sv | 40 ++++
 rtl/imem_dmem_arbiter_store_lane_gen.sv | 32 +++
 rtl/imem_dmem_arbiter.sv | 111 +++++++++++
 tb/tb_imem_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and encodings for the unified I/D memory arbiter.
package arb_pkg;

  localparam logic [1:0] MASK_BYTE = 2'b00;
  localparam logic [1:0] MASK_HALF = 2'b01;
  localparam logic [1:0] MASK_WORD = 2'b10;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

  function automatic logic [3:0] half_lanes(input logic hi);
    return hi ? 4'b1100 : 4'b0011;
  endfunction

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Core-side I/D ports, RAM port and stall, bundled for the arbiter.
interface imem_dmem_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [1:0]        d_mask;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              core_stall;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_mask, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, core_stall
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_mask, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, core_stall
  );

endinterface

// File: rtl/imem_dmem_arbiter_store_lane_gen.sv
// Store byte-lane enables and lane-replicated write data from size/offset.
module store_lane_gen
  import arb_pkg::*;
(
  input  logic [1:0]  i_mask,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic        i_we,
  output logic [3:0]  o_mem_we,
  output logic [31:0] o_mem_wdata
);

  always_comb begin
    o_mem_we    = 4'b0000;
    o_mem_wdata = i_wdata;
    case (i_mask)
      MASK_BYTE: begin
        o_mem_wdata = {4{i_wdata[7:0]}};
        o_mem_we    = 4'b0001 << i_addr_lo;
      end
      MASK_HALF: begin
        // misaligned halfwords land on their containing aligned half
        o_mem_wdata = {2{i_wdata[15:0]}};
        o_mem_we    = half_lanes(i_addr_lo[1]);
      end
      MASK_WORD: o_mem_we = 4'b1111;
      default:   o_mem_we = 4'b0000;
    endcase
    if (!i_we) o_mem_we = 4'b0000;
  end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Single-port RAM arbiter between instruction fetch (I) and load/store (D).
// ARB_ROUND_ROBIN_EN: alternate winners on contention instead of D priority + starvation guard.
module imem_dmem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int STARVE_LIM = 4
) (
  input logic                clk,
  input logic                rst_n,
  imem_dmem_arbiter_if.slave bus
);

  if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_lim_chk
    $error("STARVE_LIM must be in 1..15");
  end

  logic        w_i_gnt;
  logic        w_d_gnt;
  rd_tag_t     r_tag;
  rd_tag_t     w_tag_nxt;
  logic [3:0]  w_st_we;
  logic [31:0] w_st_wdata;
  logic        w_i_rv;
  logic        w_d_rv;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_own;
`else
  localparam logic [3:0] LIM = 4'(STARVE_LIM);
  logic [3:0] r_starve_cnt;
`endif

  always_comb begin
    w_i_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (rst_n) begin
      if (bus.i_req && bus.d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (r_last_own == OWN_D) w_i_gnt = 1'b1;
        else                     w_d_gnt = 1'b1;
`else
        if (r_starve_cnt == LIM) w_i_gnt = 1'b1;
        else                     w_d_gnt = 1'b1;
`endif
      end else if (bus.i_req) begin
        w_i_gnt = 1'b1;
      end else if (bus.d_req) begin
        w_d_gnt = 1'b1;
      end
    end
  end

  // only reads are tagged; stores (any mask) never produce an rvalid
  always_comb begin
    w_tag_nxt.valid = w_i_gnt | (w_d_gnt & ~bus.d_we);
    w_tag_nxt.owner = w_i_gnt ? OWN_I : OWN_D;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tag <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_last_own <= OWN_I;
`else
      r_starve_cnt <= '0;
`endif
    end else begin
      r_tag <= w_tag_nxt;
`ifdef ARB_ROUND_ROBIN_EN
      if (w_i_gnt)      r_last_own <= OWN_I;
      else if (w_d_gnt) r_last_own <= OWN_D;
`else
      if (!bus.i_req || w_i_gnt)
        r_starve_cnt <= '0;
      else if (w_d_gnt && r_starve_cnt != LIM)
        r_starve_cnt <= r_starve_cnt + 4'd1;
`endif
    end
  end

  store_lane_gen u_lane (
    .i_mask      (bus.d_mask),
    .i_addr_lo   (bus.d_addr[1:0]),
    .i_wdata     (bus.d_wdata),
    .i_we        (bus.d_we),
    .o_mem_we    (w_st_we),
    .o_mem_wdata (w_st_wdata)
  );

  assign bus.i_gnt     = w_i_gnt;
  assign bus.d_gnt     = w_d_gnt;
  assign bus.mem_en    = w_i_gnt | w_d_gnt;
  assign bus.mem_addr  = w_d_gnt ? bus.d_addr[ADDR_W+1:2] : bus.i_addr[ADDR_W+1:2];
  assign bus.mem_we    = w_d_gnt ? w_st_we : 4'b0000;
  assign bus.mem_wdata = w_st_wdata;

  // rst_n gating drops a read whose grant coincided with reset assertion
  assign w_i_rv       = rst_n & r_tag.valid & (r_tag.owner == OWN_I);
  assign w_d_rv       = rst_n & r_tag.valid & (r_tag.owner == OWN_D);
  assign bus.i_rvalid = w_i_rv;
  assign bus.d_rvalid = w_d_rv;
  assign bus.i_rdata  = w_i_rv ? bus.mem_rdata : 32'h0;
  assign bus.d_rdata  = w_d_rv ? bus.mem_rdata : 32'h0;

  assign bus.core_stall = bus.i_req & ~w_i_gnt;

  logic w_unused;
  assign w_unused = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0], bus.d_addr[31:ADDR_W+2]};

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter with a behavioural 1-cycle RAM.
module tb_imem_dmem_arbiter;
  import arb_pkg::*;

  localparam int ADDR_W     = 12;
  localparam int STARVE_LIM = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  imem_dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIM(STARVE_LIM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  bit preload = 1'b1;

  function automatic logic [31:0] init_word(input int k);
    return 32'hC0DE_0000 | 32'(k);
  endfunction

  // behavioural single-port RAM, read-before-write
  logic [31:0] ram [0:63];
  logic [31:0] r_ram_q;
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 64; k++) ram[k] <= init_word(k);
    end else if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) ram[bus.mem_addr[5:0]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      r_ram_q <= ram[bus.mem_addr[5:0]];
    end
  end
  assign bus.mem_rdata = r_ram_q;

  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    logic        own;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  // rvalid/rdata monitor: pops the expectation due in this cycle
  always @(negedge clk) begin
    exp_t        e;
    logic        ei, ed;
    logic [31:0] edat;
    #3;
    if (mon_en) begin
      ei = 1'b0; ed = 1'b0; edat = 32'h0;
      while (sbq.size() > 0 && sbq[0].due < cyc) begin
        e = sbq.pop_front();
        total++; bad++;
        $display("FAIL rvalid_missing due=%0d now=%0d", e.due, cyc);
      end
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        ei = (e.own == OWN_I); ed = (e.own == OWN_D); edat = e.data;
      end
      total++;
      if (bus.i_rvalid !== ei) begin bad++; $display("FAIL i_rvalid cyc=%0d got=%b want=%b", cyc, bus.i_rvalid, ei); end
      total++;
      if (bus.d_rvalid !== ed) begin bad++; $display("FAIL d_rvalid cyc=%0d got=%b want=%b", cyc, bus.d_rvalid, ed); end
      total++;
      if (bus.i_rdata !== (ei ? edat : 32'h0)) begin bad++; $display("FAIL i_rdata cyc=%0d got=%h want=%h", cyc, bus.i_rdata, ei ? edat : 32'h0); end
      total++;
      if (bus.d_rdata !== (ed ? edat : 32'h0)) begin bad++; $display("FAIL d_rdata cyc=%0d got=%h want=%h", cyc, bus.d_rdata, ed ? edat : 32'h0); end
    end
  end

  // applies one cycle of stimulus at the falling edge, returns mid-cycle
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [1:0] dm, input logic [31:0] da, input logic [31:0] dwd);
    @(negedge clk);
    bus.i_req = ir; bus.i_addr = ia;
    bus.d_req = dr; bus.d_we = dw; bus.d_mask = dm; bus.d_addr = da; bus.d_wdata = dwd;
    #2;
  endtask

  task automatic push(input logic own, input logic [31:0] data);
    sbq.push_back('{cyc + 1, own, data});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    preload = 1'b0;
    mon_en = 1'b1;
    total++; if (bus.mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en got=%b want=0", bus.mem_en); end
    total++; if (bus.mem_we !== 4'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0000", bus.mem_we); end
    total++; if (bus.core_stall !== 1'b0) begin bad++; $display("FAIL rst_stall_idle got=%b want=0", bus.core_stall); end
    drive(1, 32'h10, 1, 1, MASK_WORD, 32'h20, 32'h5555_5555);
    total++; if (bus.i_gnt !== 1'b0) begin bad++; $display("FAIL rst_i_gnt got=%b want=0", bus.i_gnt); end
    total++; if (bus.d_gnt !== 1'b0) begin bad++; $display("FAIL rst_d_gnt got=%b want=0", bus.d_gnt); end
    total++; if (bus.mem_en !== 1'b0) begin bad++; $display("FAIL rst_req_mem_en got=%b want=0", bus.mem_en); end
    total++; if (bus.mem_we !== 4'b0) begin bad++; $display("FAIL rst_req_mem_we got=%b want=0000", bus.mem_we); end
    total++; if (bus.core_stall !== 1'b1) begin bad++; $display("FAIL rst_stall_req got=%b want=1", bus.core_stall); end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

`ifdef ARB_ROUND_ROBIN_EN
  task automatic test_round_robin();
    logic ei;
    for (int k = 0; k < 6; k++) begin
      ei = (k % 2) == 1;
      drive(1, 32'h10, 1, 0, MASK_WORD, 32'h20, 0);
      total++; if (bus.i_gnt !== ei) begin bad++; $display("FAIL rr_i_gnt k=%0d got=%b want=%b", k, bus.i_gnt, ei); end
      total++; if (bus.d_gnt !== !ei) begin bad++; $display("FAIL rr_d_gnt k=%0d got=%b want=%b", k, bus.d_gnt, !ei); end
      push(ei ? OWN_I : OWN_D, init_word(ei ? 4 : 8));
    end
  endtask
`else
  task automatic test_starvation();
    logic ei;
    for (int k = 0; k < 10; k++) begin
      ei = (k == 4) || (k == 9);
      drive(1, 32'h10, 1, 0, MASK_WORD, 32'h20, 0);
      total++; if (bus.i_gnt !== ei) begin bad++; $display("FAIL starve_i_gnt k=%0d got=%b want=%b", k, bus.i_gnt, ei); end
      total++; if (bus.d_gnt !== !ei) begin bad++; $display("FAIL starve_d_gnt k=%0d got=%b want=%b", k, bus.d_gnt, !ei); end
      total++; if (bus.core_stall !== !ei) begin bad++; $display("FAIL starve_stall k=%0d got=%b want=%b", k, bus.core_stall, !ei); end
      total++; if (bus.mem_addr !== ADDR_W'(ei ? 4 : 8)) begin bad++; $display("FAIL starve_addr k=%0d got=%h want=%h", k, bus.mem_addr, ei ? 4 : 8); end
      push(ei ? OWN_I : OWN_D, init_word(ei ? 4 : 8));
    end
  endtask
`endif

  task automatic test_i_only();
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h10, 0, 0, 0, 0, 0);
      total++; if (bus.i_gnt !== 1'b1) begin bad++; $display("FAIL ionly_gnt k=%0d got=%b want=1", k, bus.i_gnt); end
      total++; if (bus.mem_addr !== ADDR_W'(4)) begin bad++; $display("FAIL ionly_addr k=%0d got=%h want=4", k, bus.mem_addr); end
      total++; if (bus.mem_we !== 4'b0) begin bad++; $display("FAIL ionly_we k=%0d got=%b want=0000", k, bus.mem_we); end
      total++; if (bus.core_stall !== 1'b0) begin bad++; $display("FAIL ionly_stall k=%0d got=%b want=0", k, bus.core_stall); end
      push(OWN_I, init_word(4));
    end
  endtask

  task automatic test_store_byte();
    drive(0, 0, 1, 1, MASK_BYTE, 32'h7, 32'hAB);
    total++; if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL sb_gnt got=%b want=1", bus.d_gnt); end
    total++; if (bus.mem_we !== 4'b1000) begin bad++; $display("FAIL sb_we got=%b want=1000", bus.mem_we); end
    total++; if (bus.mem_wdata !== 32'hABAB_ABAB) begin bad++; $display("FAIL sb_wdata got=%h want=abababab", bus.mem_wdata); end
    total++; if (bus.mem_addr !== ADDR_W'(1)) begin bad++; $display("FAIL sb_addr got=%h want=1", bus.mem_addr); end
    drive(0, 0, 1, 0, MASK_WORD, 32'h4, 0);
    total++; if (bus.mem_we !== 4'b0) begin bad++; $display("FAIL sb_ld_we got=%b want=0000", bus.mem_we); end
    push(OWN_D, 32'hABDE_0001);
  endtask

  task automatic test_store_half();
    drive(0, 0, 1, 1, MASK_HALF, 32'h6, 32'h1234);
    total++; if (bus.mem_we !== 4'b1100) begin bad++; $display("FAIL sh_we got=%b want=1100", bus.mem_we); end
    total++; if (bus.mem_wdata !== 32'h1234_1234) begin bad++; $display("FAIL sh_wdata got=%h want=12341234", bus.mem_wdata); end
    total++; if (bus.mem_addr !== ADDR_W'(1)) begin bad++; $display("FAIL sh_addr got=%h want=1", bus.mem_addr); end
    drive(0, 0, 1, 0, MASK_WORD, 32'h4, 0);
    total++; if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL sh_ld_gnt got=%b want=1", bus.d_gnt); end
    push(OWN_D, 32'h1234_0001);
  endtask

  task automatic test_store_word_reserved();
    drive(0, 0, 1, 1, MASK_WORD, 32'hB, 32'hDEAD_BEEF);
    total++; if (bus.mem_we !== 4'b1111) begin bad++; $display("FAIL sw_we got=%b want=1111", bus.mem_we); end
    total++; if (bus.mem_addr !== ADDR_W'(2)) begin bad++; $display("FAIL sw_addr got=%h want=2", bus.mem_addr); end
    drive(0, 0, 1, 1, 2'b11, 32'hC, 32'hFFFF_FFFF);
    total++; if (bus.d_gnt !== 1'b1) begin bad++; $display("FAIL rsv_gnt got=%b want=1", bus.d_gnt); end
    total++; if (bus.mem_we !== 4'b0) begin bad++; $display("FAIL rsv_we got=%b want=0000", bus.mem_we); end
    drive(0, 0, 1, 0, MASK_WORD, 32'h8, 0);
    push(OWN_D, 32'hDEAD_BEEF);
    drive(0, 0, 1, 0, MASK_WORD, 32'hC, 0);
    push(OWN_D, init_word(3));
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) drive(1, 32'(4 * (5 + k)), 0, 0, 0, 0, 0);
      else            drive(0, 0, 1, 0, MASK_WORD, 32'(4 * (5 + k)), 0);
      total++; if (bus.mem_addr !== ADDR_W'(5 + k)) begin bad++; $display("FAIL b2b_addr k=%0d got=%h want=%h", k, bus.mem_addr, 5 + k); end
      total++; if ({bus.i_gnt, bus.d_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL b2b_gnt k=%0d got=%b%b want=%s", k, bus.i_gnt, bus.d_gnt, (k % 2 == 0) ? "10" : "01");
      end
      push((k % 2 == 0) ? OWN_I : OWN_D, init_word(5 + k));
    end
  endtask

  task automatic test_reset_drop();
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 32'h10, 0, 0, 0, 0, 0);
    total++; if (bus.i_gnt !== 1'b1) begin bad++; $display("FAIL drop_gnt got=%b want=1", bus.i_gnt); end
    #2 rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    total++; if ({bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.core_stall} !== 8'h0) begin
      bad++; $display("FAIL drop_outputs got=%b want=0", {bus.i_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.core_stall});
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    drive(1, 32'h10, 0, 0, 0, 0, 0);
    total++; if (bus.i_gnt !== 1'b1) begin bad++; $display("FAIL post_rst_gnt got=%b want=1", bus.i_gnt); end
    push(OWN_I, init_word(4));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_req = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_mask = 0; bus.d_addr = 0; bus.d_wdata = 0;
    test_reset();
`ifdef ARB_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_starvation();
`endif
    test_i_only();
    test_store_byte();
    test_store_half();
    test_store_word_reserved();
    test_back_to_back();
    test_reset_drop();
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2;
    total++; if (sbq.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sbq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
